table_rom_arbiter: RTL and testbench
====================================

# table_rom_arbiter

Shares the single table/background image-ROM read path (image ROM followed by palette lookup) among up to N_REQ requesters, e.g. the display pixel pipeline, a counter-highlight overlay and the game-logic occupancy probe. Each requester presents a ROM address with a req/grant handshake. The arbiter drives one address per cycle into the ROM chain and tracks every in-flight read. It then returns the palette-mapped pixel to the requester that issued it, with a fixed latency.

## Interface
- N_REQ, 4, number of requesters (2..8)
- ADDR_WIDTH, 17, image ROM address width
- DATA_WIDTH, 12, palette-mapped pixel width (4:4:4 RGB)
- ROM_LATENCY, 2, cycles from rom_addr_out to matching rom_data_in (≥1)
- pixel_clk_in  input  1  single clock; all logic on posedge
- rst_in  input  1  synchronous, active-high reset
- req_in  input  N_REQ  per-requester read request
- addr_in  input  N_REQ*ADDR_WIDTH  requester i address in bits [i*ADDR_WIDTH +: ADDR_WIDTH]
- grant_out  output  N_REQ  combinational one-hot grant; at most one bit high
- rom_addr_out  output  ADDR_WIDTH  registered address to image ROM
- rom_en_out  output  1  registered; high when rom_addr_out carries a real read
- rom_data_in  input  DATA_WIDTH  palette-mapped pixel from ROM chain
- valid_out  output  N_REQ  registered one-hot; read data returning to requester i
- data_out  output  DATA_WIDTH  registered returned pixel, shared by all requesters

## Operation
- Transfer occurs in cycle H when req_in[i]=1 and grant_out[i]=1. The requester may change addr_in or drop req at the next edge. Back-to-back transfers are allowed.
- grant_out is a function only of req_in and the round-robin pointer. No grant is issued when req_in=0.
- The requester must hold req_in[i] and its address stable until granted. The arbiter never drops a request.
- Round robin: search starts at ptr, which resets to 0. After a grant to i, ptr = (i+1) mod N_REQ.
- In-flight tracking: a tag shift register of depth ROM_LATENCY+1 carries a valid bit plus the requester index (clog2(N_REQ) bits). It advances every cycle with no stall. Up to ROM_LATENCY+1 reads are outstanding.
- The ROM chain is never stalled, so there is no backpressure on returns. A requester must accept valid_out whenever it arrives.
- When the tag head is invalid, data_out holds its last value.
- Reset (at any time, including with reads in flight):
  - All tags are cleared; ptr = 0.
  - rom_addr_out=0, rom_en_out=0, valid_out=0, data_out=0.
  - In-flight reads are discarded and never reported.
  - grant_out is forced to 0 during the rst_in cycle.

## Timing
- Cycle H: handshake; grant_out is high combinationally.
- H+1: rom_addr_out = granted address, rom_en_out=1.
- H+1+ROM_LATENCY: rom_data_in valid.
- H+2+ROM_LATENCY: valid_out[i]=1 for one cycle and data_out = that pixel. With ROM_LATENCY=2, total latency is 4 cycles.
- Returns arrive in issue order. A requester issuing every cycle receives valid_out every cycle.
- With no transfer in cycle H, rom_en_out=0 in H+1 and rom_addr_out holds its previous value.

## Configuration
- TABLE_ROM_ARB_PRIORITY0_EN defined:
  - Requester 0 (the display pipeline) has strict priority. Whenever req_in[0]=1, grant_out=1 (bit 0), regardless of ptr.
  - Requesters 1..N_REQ-1 share the remaining cycles round-robin.
  - ptr ranges over 1..N_REQ-1, resets to 1, and is updated only on grants to 1..N_REQ-1.
- Not defined: all N_REQ requesters are pure round-robin as described in Operation, with ptr starting at 0.

## Test plan
- Single requester, latency check: req_in=4'b0010, addr 100, one cycle.
  - grant_out=4'b0010 in H; rom_addr_out=100 with rom_en_out=1 in H+1.
  - ROM model returns 12'hB70 at H+3; valid_out=4'b0010 and data_out=12'hB70 at H+4.
- Round-robin fairness, macro off: all four requesters hold req for 8 cycles.
  - Grant order is 0,1,2,3,0,1,2,3.
  - valid_out follows the same order 4 cycles later, each paired with its own address's data.
- Priority, macro on: req_in[0] held high for 6 cycles while req 1 and 2 are high.
  - grant_out=4'b0001 for all 6 cycles.
  - Afterwards the grants are 1, then 2; ptr starts at 1.
- Stable-hold rule: req 3 is held with addr 500 while requesters 0-2 win.
  - Req 3 is granted within N_REQ cycles with address 500.
  - No grant_out bit is ever high on a cycle with its req_in low.
- Reset mid-operation: 3 reads in flight, then assert rst_in for 1 cycle.
  - valid_out stays 0 for ROM_LATENCY+2 cycles after reset; rom_en_out=0; data_out=0; ptr is back to its reset value.
- Back-to-back single requester: req 2 streams addrs 0..9 on consecutive cycles.
  - valid_out[2] is high for 10 consecutive cycles.
  - Data arrives in address order.

Source files
------------

// File: rtl/table_rom_arbiter.sv
// table_rom_arbiter: shares the image-ROM -> palette read path among N_REQ
// requesters. Round-robin grant, one ROM read per cycle, fixed-latency return
// routed back to the issuing requester by a tag shift register.
// Optional build macro: TABLE_ROM_ARB_PRIORITY0_EN gives requester 0 strict
// priority; the rest share the leftover cycles round-robin.
module table_rom_arbiter #(
  parameter int N_REQ       = 4,
  parameter int ADDR_WIDTH  = 17,
  parameter int DATA_WIDTH  = 12,
  parameter int ROM_LATENCY = 2
) (
  input  logic                        pixel_clk_in,
  input  logic                        rst_in,
  input  logic [N_REQ-1:0]            req_in,
  input  logic [N_REQ*ADDR_WIDTH-1:0] addr_in,
  output logic [N_REQ-1:0]            grant_out,
  output logic [ADDR_WIDTH-1:0]       rom_addr_out,
  output logic                        rom_en_out,
  input  logic [DATA_WIDTH-1:0]       rom_data_in,
  output logic [N_REQ-1:0]            valid_out,
  output logic [DATA_WIDTH-1:0]       data_out
);

  localparam int IDX_W = $clog2(N_REQ);
`ifdef TABLE_ROM_ARB_PRIORITY0_EN
  localparam logic [IDX_W-1:0] PTR_RST = IDX_W'(1);
`else
  localparam logic [IDX_W-1:0] PTR_RST = '0;
`endif

  logic [IDX_W-1:0]                  ptr;
  logic [IDX_W-1:0]                  gnt_idx;
  logic                              gnt_any;
  logic [ADDR_WIDTH-1:0]             gnt_addr;
  logic [ROM_LATENCY:0]              vld_pipe;
  logic [ROM_LATENCY:0][IDX_W-1:0]   tag_pipe;
  logic [N_REQ-1:0]                  ret_oh;

  // Pick the first requesting index at or after ptr (rotating search).
  always_comb begin
    int t;
    t       = 0;
    gnt_any = 1'b0;
    gnt_idx = '0;
`ifdef TABLE_ROM_ARB_PRIORITY0_EN
    if (req_in[0]) begin
      gnt_any = 1'b1;
    end else begin
      // ptr lives in 1..N_REQ-1; rotate over that sub-range only
      for (int k = 0; k < N_REQ-1; k++) begin
        t = int'(ptr) - 1 + k;
        if (t >= N_REQ-1) t = t - (N_REQ-1);
        t = t + 1;
        if (!gnt_any && req_in[t]) begin
          gnt_any = 1'b1;
          gnt_idx = IDX_W'(t);
        end
      end
    end
`else
    for (int k = 0; k < N_REQ; k++) begin
      t = int'(ptr) + k;
      if (t >= N_REQ) t = t - N_REQ;
      if (!gnt_any && req_in[t]) begin
        gnt_any = 1'b1;
        gnt_idx = IDX_W'(t);
      end
    end
`endif
    // no handshake may complete in a reset cycle
    if (rst_in) gnt_any = 1'b0;
  end

  // Decode grant index to one-hot and select the winner's address.
  always_comb begin
    grant_out = '0;
    if (gnt_any) grant_out[gnt_idx] = 1'b1;
    gnt_addr = addr_in[gnt_idx*ADDR_WIDTH +: ADDR_WIDTH];
  end

  // Rotate pointer past the winner; register the ROM address and enable.
  always_ff @(posedge pixel_clk_in) begin
    if (rst_in) begin
      ptr          <= PTR_RST;
      rom_addr_out <= '0;
      rom_en_out   <= 1'b0;
    end else begin
      rom_en_out <= gnt_any;
      if (gnt_any) rom_addr_out <= gnt_addr;
`ifdef TABLE_ROM_ARB_PRIORITY0_EN
      if (gnt_any && gnt_idx != '0)
        ptr <= (gnt_idx == IDX_W'(N_REQ-1)) ? IDX_W'(1) : gnt_idx + IDX_W'(1);
`else
      if (gnt_any)
        ptr <= (gnt_idx == IDX_W'(N_REQ-1)) ? '0 : gnt_idx + IDX_W'(1);
`endif
    end
  end

  // Tag pipeline: stage ROM_LATENCY lines up with rom_data_in for that read.
  always_ff @(posedge pixel_clk_in) begin
    if (rst_in) begin
      vld_pipe <= '0;
      tag_pipe <= '0;
    end else begin
      vld_pipe <= {vld_pipe[ROM_LATENCY-1:0], gnt_any};
      tag_pipe <= {tag_pipe[ROM_LATENCY-1:0], gnt_idx};
    end
  end

  // Route the returning tag to a one-hot valid.
  always_comb begin
    ret_oh = '0;
    if (vld_pipe[ROM_LATENCY]) ret_oh[tag_pipe[ROM_LATENCY]] = 1'b1;
  end

  // Register the return; data holds when nothing is returning.
  always_ff @(posedge pixel_clk_in) begin
    if (rst_in) begin
      valid_out <= '0;
      data_out  <= '0;
    end else begin
      valid_out <= ret_oh;
      if (vld_pipe[ROM_LATENCY]) data_out <= rom_data_in;
    end
  end

endmodule

// File: tb/tb_table_rom_arbiter.sv
// Bench for table_rom_arbiter: directed steps from the test plan followed by
// randomized traffic, all checked against a transaction-level model
// (rotating-priority pick, return queue keyed by due cycle).
module tb_table_rom_arbiter;
  localparam int N  = 4;
  localparam int AW = 17;
  localparam int DW = 12;
  localparam int L  = 2;
`ifdef TABLE_ROM_ARB_PRIORITY0_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      req;
  logic [N*AW-1:0]   addr;
  logic [N-1:0]      grant_out;
  logic [AW-1:0]     rom_addr_out;
  logic              rom_en_out;
  logic [DW-1:0]     rom_data_in;
  logic [N-1:0]      valid_out;
  logic [DW-1:0]     data_out;

  table_rom_arbiter #(.N_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ROM_LATENCY(L)) dut (
    .pixel_clk_in(clk), .rst_in(rst), .req_in(req), .addr_in(addr),
    .grant_out(grant_out), .rom_addr_out(rom_addr_out), .rom_en_out(rom_en_out),
    .rom_data_in(rom_data_in), .valid_out(valid_out), .data_out(data_out));

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] rom_f(input logic [AW-1:0] a);
    return DW'(int'(a) * 29 + 28);
  endfunction

  // ROM chain model: L-cycle pipeline from rom_addr_out to rom_data_in
  logic [DW-1:0] rom_pipe [L];
  always @(posedge clk) begin
    rom_pipe[0] <= rom_f(rom_addr_out);
    for (int k = 1; k < L; k++) rom_pipe[k] <= rom_pipe[k-1];
  end
  assign rom_data_in = rom_pipe[L-1];

  typedef struct { int due; int idx; logic [DW-1:0] data; } ret_t;
  ret_t q[$];

  int checks = 0, errors = 0;
  int cyc = 0, ptr_m = 0, last_gi = -1;
  bit regs_ok = 1'b0;
  logic          exp_en;
  logic [AW-1:0] exp_addr;
  logic [DW-1:0] last_data;
  int run2 = 0, maxrun2 = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Reference pick: first requester at or after ptr in rotation order
  function automatic int model_grant(input logic [N-1:0] r);
    if (PRIO) begin
      if (r[0]) return 0;
      for (int k = 0; k < N-1; k++)
        if (r[1 + (ptr_m - 1 + k) % (N-1)]) return 1 + (ptr_m - 1 + k) % (N-1);
    end else begin
      for (int k = 0; k < N; k++)
        if (r[(ptr_m + k) % N]) return (ptr_m + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [AW-1:0] addr_of(input int i);
    return addr[i*AW +: AW];
  endfunction

  // One clock cycle: check outputs mid-cycle, advance model, cross the edge.
  task automatic tick();
    int gi;
    logic [N-1:0] eg, ev;
    logic [DW-1:0] ed;
    #1;
    gi = rst ? -1 : model_grant(req);
    eg = (gi < 0) ? '0 : N'(1) << gi;
    chk("grant", 32'(grant_out), 32'(eg));
    chk("grant_without_req", 32'(grant_out & ~req), 32'd0);
    if (regs_ok) begin
      chk("rom_en", 32'(rom_en_out), 32'(exp_en));
      chk("rom_addr", 32'(rom_addr_out), 32'(exp_addr));
      ev = '0;
      ed = last_data;
      if (q.size() > 0 && q[0].due == cyc) begin
        ev = N'(1) << q[0].idx;
        ed = q[0].data;
        void'(q.pop_front());
      end
      chk("valid_out", 32'(valid_out), 32'(ev));
      chk("data_out", 32'(data_out), 32'(ed));
      last_data = ed;
    end
    if (valid_out[2] === 1'b1) run2++; else run2 = 0;
    if (run2 > maxrun2) maxrun2 = run2;
    if (rst) begin
      ptr_m = PRIO ? 1 : 0;
      q.delete();
      exp_en = 1'b0; exp_addr = '0; last_data = '0;
      regs_ok = 1'b1;
    end else begin
      exp_en = (gi >= 0);
      if (gi >= 0) begin
        exp_addr = addr_of(gi);
        q.push_back('{cyc + L + 2, gi, rom_f(exp_addr)});
        if (PRIO) begin
          if (gi != 0) ptr_m = (gi % (N-1)) + 1;
        end else ptr_m = (gi + 1) % N;
      end
    end
    last_gi = gi;
    cyc++;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    req = '0;
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic do_reset();
    rst = 1'b1; tick(); rst = 1'b0;
  endtask

  initial begin
    bit got;
    rst = 1'b1; req = '0; addr = '0;
    @(negedge clk);
    tick();
    rst = 1'b0;

    // reset state
    #1;
    chk("reset_rom_en", 32'(rom_en_out), 32'd0);
    chk("reset_valid", 32'(valid_out), 32'd0);
    chk("reset_data", 32'(data_out), 32'd0);

    // single requester latency
    req = 4'b0010; addr[1*AW +: AW] = 17'd100;
    #1 chk("t1_grant", 32'(grant_out), 32'h2);
    tick();
    req = '0;
    #1 chk("t1_rom_addr", 32'(rom_addr_out), 32'd100);
    chk("t1_rom_en", 32'(rom_en_out), 32'd1);
    tick(); tick(); tick();
    #1 chk("t1_valid", 32'(valid_out), 32'h2);
    chk("t1_data", 32'(data_out), 32'hB70);
    idle(3);

    do_reset();
    if (!PRIO) begin
      // round-robin fairness
      req = 4'b1111;
      for (int i = 0; i < N; i++) addr[i*AW +: AW] = AW'(200 + i);
      for (int k = 0; k < 8; k++) begin
        #1 chk("t2_rr_order", 32'(grant_out), 32'(N'(1) << (k % N)));
        tick();
      end
    end else begin
      // requester 0 strict priority
      req = 4'b0111;
      for (int i = 0; i < N; i++) addr[i*AW +: AW] = AW'(300 + i);
      for (int k = 0; k < 6; k++) begin
        #1 chk("t2_prio0", 32'(grant_out), 32'h1);
        tick();
      end
      req = 4'b0110;
      #1 chk("t2_after_prio_1", 32'(grant_out), 32'h2);
      tick();
      req = 4'b0100;
      #1 chk("t2_after_prio_2", 32'(grant_out), 32'h4);
      tick();
    end
    idle(L + 3);

    // stable hold: requester 3 waits with address 500 while 0..2 win once each
    req = 4'b1111;
    for (int i = 0; i < 3; i++) addr[i*AW +: AW] = AW'(40 + i);
    addr[3*AW +: AW] = 17'd500;
    got = 1'b0;
    for (int k = 0; k < N && !got; k++) begin
      tick();
      if (last_gi == 3) got = 1'b1;
      else if (last_gi >= 0) req[last_gi] = 1'b0;
    end
    chk("t3_req3_granted", 32'(got), 32'd1);
    req = '0;
    #1 chk("t3_req3_addr", 32'(rom_addr_out), 32'd500);
    idle(L + 3);

    // reset with reads in flight
    req = 4'b0111;
    tick(); tick(); tick();
    req = '0;
    do_reset();
    for (int k = 0; k < L + 2; k++) begin
      #1 chk("t4_valid_quiet", 32'(valid_out), 32'd0);
      chk("t4_rom_en", 32'(rom_en_out), 32'd0);
      chk("t4_data_zero", 32'(data_out), 32'd0);
      tick();
    end
    req = 4'b1110;
    #1 chk("t4_ptr_reset", 32'(grant_out), 32'h2);
    tick();
    idle(L + 3);

    // back-to-back stream from requester 2
    maxrun2 = 0;
    req = 4'b0100;
    for (int k = 0; k < 10; k++) begin
      addr[2*AW +: AW] = AW'(k);
      tick();
    end
    idle(L + 4);
    chk("t5_streak", 32'(maxrun2), 32'd10);

    // randomized traffic under the hold rule, occasional resets
    for (int k = 0; k < 400; k++) begin
      rst = ($urandom_range(0, 59) == 0);
      tick();
      rst = 1'b0;
      for (int i = 0; i < N; i++) begin
        if (req[i] && last_gi == i) begin
          req[i] = $urandom_range(0, 1);
          addr[i*AW +: AW] = AW'($urandom);
        end else if (!req[i] && $urandom_range(0, 2) == 0) begin
          req[i] = 1'b1;
          addr[i*AW +: AW] = AW'($urandom);
        end
      end
    end
    idle(L + 4);
    chk("drain_empty", 32'(q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
